game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Parametrised per-frame game-state sequencer in the gameclk (60 Hz) domain.
- Generalises the ghost-eaten count, score-pause detection and ghost animation toggle to N ghosts.
- Adds a frightened-mode timer with end-of-fright flashing, a sequential ghost-eat combo with queued simultaneous eats, and a death freeze.
- Feeds pause, frightened and animation state to the ghost, pacman and graphics blocks.

Parameters:
- N_GHOSTS, 4: number of ghost channels.
- FRIGHT_FRAMES, 360: frightened duration in frames.
- FLASH_FRAMES, 120: final frightened frames during which flashing is enabled.
- SCORE_PAUSE_FRAMES, 60: freeze length after each ghost eaten.
- DEATH_FRAMES, 90: freeze length after pacman death.
- ANIM_DIV, 8: frames per ghost-animation toggle.

Ports:
- clk  in  1  game clock, one edge per frame.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level; leaves IDLE.
- power_pellet  in  1  pulse; pellet eaten this frame.
- ghost_eaten  in  N_GHOSTS  per-ghost pulse; collision with a frightened ghost.
- pacman_dead  in  1  pulse.
- state  out  2  0 IDLE, 1 PLAY, 2 SCORE, 3 DEATH.
- pause  out  1  high in SCORE and DEATH.
- frightened  out  1  fright timer nonzero.
- fright_flash  out  1  flashing colour select.
- eaten_ghost  out  $clog2(N_GHOSTS)  index of the ghost being scored.
- combo_idx  out  2  0..3, maps to 200/400/800/1600 points.
- score_add  out  12  points to add; valid for one cycle.
- ghost_animation  out  1  sprite-frame toggle.

Behaviour:
- Reset: every output and register is 0, state is IDLE, pending mask cleared. Reset takes priority over all inputs in any state, including mid-pause.
- IDLE:
  - Holds all timers and counters.
  - start=1 moves to PLAY on the next edge.
  - All other inputs are ignored.
- PLAY:
  - fright_timer decrements by 1 per frame while nonzero.
  - power_pellet reloads fright_timer to FRIGHT_FRAMES and clears combo_idx to 0. This applies even while already frightened.
  - Eat capture: on any ghost_eaten bit with frightened=1, OR it into the pending mask. Eats arriving while frightened=0 are ignored.
  - If pending is nonzero at the edge, select the lowest set index:
    - eaten_ghost is set to that index.
    - score_add = 200 << combo_idx, pulsed for exactly one cycle.
    - That pending bit is cleared.
    - State moves to SCORE and pause_cnt loads SCORE_PAUSE_FRAMES-1.
  - combo_idx increments after each scored eat and saturates at 3.
  - Eat capture and the SCORE transition happen in the same edge, so a single eat produces score_add on the following cycle.
- Priority when events coincide in one frame: pacman_dead > ghost eat > power_pellet reload.
  - A power_pellet in the same frame as an eat still reloads the timer.
  - combo_idx clears before the eat is scored, so that eat scores 200.
- SCORE:
  - pause=1; fright_timer and anim counter are frozen.
  - New ghost_eaten bits are still ORed into pending.
  - pause_cnt decrements by 1 per frame. At 0, go to PLAY if pending is 0; otherwise score the next pending ghost immediately and reload pause_cnt.
  - Simultaneous eats are therefore serialised one per pause, with combo increasing across them.
- DEATH:
  - Entered from PLAY or SCORE on pacman_dead.
  - On entry: pending, fright_timer and combo_idx are cleared; pause=1.
  - After DEATH_FRAMES frames, return to PLAY.
- fright_flash = frightened & (fright_timer <= FLASH_FRAMES) & fright_timer[3], giving an 8-frame blink.
- Animation:
  - anim_cnt counts 0..ANIM_DIV-1 only in PLAY.
  - ghost_animation toggles on each wrap to 0.
  - In SCORE, DEATH and IDLE the count and the toggle hold.
- Widths:
  - Timers are $clog2(max frames + 1) bits.
  - score_add is zero-extended.
  - combo_idx saturation must hold for N_GHOSTS > 4, capping scores at 1600.

Decomposition:
- Package game_pkg:
  - state enum (IDLE/PLAY/SCORE/DEATH).
  - BASE_GHOST_SCORE = 200.
  - Score width constant.
- Sub-module frame_timer:
  - Loadable down-counter with load, enable, value and zero outputs.
  - Instanced for fright_timer and pause_cnt.
- Lowest-set-bit priority encoder is a function in game_pkg.

Test Plan:
- Reset then start=1 for 1 cycle -> state=1, pause=0, ghost_animation toggles every 8 frames.
- power_pellet in PLAY -> frightened=1 for 360 frames. fright_flash first high when fright_timer=120 with bit3 set. frightened falls exactly at frame 360.
- ghost_eaten=4'b0100 during fright -> next cycle score_add=200, eaten_ghost=2, state=2 for 60 frames. fright_timer unchanged across the pause; anim frozen.
- ghost_eaten=4'b1011 in one frame -> three pauses in order ghost 0,1,3 with score_add 200,400,800. A fourth eat later scores 1600; a fifth eat (N_GHOSTS=5 build) also scores 1600.
- pacman_dead mid-SCORE with pending bit set -> state=3, pending cleared, frightened=0, pause=1 for 90 frames, then state=1 with combo_idx=0.
- rst asserted during SCORE -> next edge: all outputs 0, state IDLE. ghost_eaten with frightened=0 -> no score_add.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types, constants and helpers for the per-frame game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    SCORE = 2'd2,
    DEATH = 2'd3
  } state_t;

  localparam int BASE_GHOST_SCORE = 200;
  localparam int SCORE_W          = 12;
  localparam int COMBO_W          = 2;
  localparam int MAX_GHOSTS       = 32;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [4:0] lowest_set(input logic [MAX_GHOSTS-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = MAX_GHOSTS - 1; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

  // Combo steps 0..3 and then sticks, so scores cap at 1600 however many ghosts exist.
  function automatic logic [COMBO_W-1:0] combo_next(input logic [COMBO_W-1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; stops at zero, load wins over enable.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         zero
);

  // Count register: load has priority, otherwise decrement while enabled and nonzero.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/game_sequencer.sv
// Per-frame game-state sequencer: play/score/death freeze, fright timer,
// serialised ghost-eat combo scoring and ghost animation toggle.
module game_sequencer
  import game_pkg::*;
#(
  parameter int N_GHOSTS           = 4,
  parameter int FRIGHT_FRAMES      = 360,
  parameter int FLASH_FRAMES       = 120,
  parameter int SCORE_PAUSE_FRAMES = 60,
  parameter int DEATH_FRAMES       = 90,
  parameter int ANIM_DIV           = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      power_pellet,
  input  logic [N_GHOSTS-1:0]                       ghost_eaten,
  input  logic                                      pacman_dead,
  output logic [1:0]                                state,
  output logic                                      pause,
  output logic                                      frightened,
  output logic                                      fright_flash,
  output logic [((N_GHOSTS > 1) ? $clog2(N_GHOSTS) : 1)-1:0] eaten_ghost,
  output logic [1:0]                                combo_idx,
  output logic [11:0]                               score_add,
  output logic                                      ghost_animation
);

  localparam int IDX_W     = (N_GHOSTS > 1) ? $clog2(N_GHOSTS) : 1;
  localparam int FRIGHT_W  = $clog2(FRIGHT_FRAMES + 1);
  localparam int PAUSE_MAX = (SCORE_PAUSE_FRAMES > DEATH_FRAMES) ? SCORE_PAUSE_FRAMES : DEATH_FRAMES;
  localparam int PAUSE_W   = $clog2(PAUSE_MAX + 1);
  localparam int ANIM_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  state_t              cur_state;
  logic [N_GHOSTS-1:0] pending;
  logic [ANIM_W-1:0]   anim_cnt;

  logic [FRIGHT_W-1:0] fright_val;
  logic                fright_zero;
  logic                fright_load;
  logic [FRIGHT_W-1:0] fright_load_val;
  logic                fright_en;

  logic [PAUSE_W-1:0]  pause_cnt_unused;
  logic                pause_zero;
  logic                pause_load;
  logic [PAUSE_W-1:0]  pause_load_val;
  logic                pause_en;

  logic                in_play;
  logic                in_score;
  logic                in_death;
  logic                go_death;
  logic                do_score;
  logic [N_GHOSTS-1:0] pend_next;
  logic [N_GHOSTS-1:0] clr_mask;
  logic [IDX_W-1:0]    sel_idx;
  logic [COMBO_W-1:0]  combo_base;
  logic [SCORE_W-1:0]  score_val;

  frame_timer #(.W(FRIGHT_W)) u_fright_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (fright_load),
    .load_val (fright_load_val),
    .en       (fright_en),
    .value    (fright_val),
    .zero     (fright_zero)
  );

  frame_timer #(.W(PAUSE_W)) u_pause_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (pause_load),
    .load_val (pause_load_val),
    .en       (pause_en),
    .value    (pause_cnt_unused),
    .zero     (pause_zero)
  );

  assign frightened   = ~fright_zero;
  assign fright_flash = frightened & (fright_val <= FRIGHT_W'(FLASH_FRAMES)) & fright_val[3];
  assign pause        = in_score | in_death;
  assign state        = cur_state;

  // Shared frame decisions: eat capture, next ghost to score, timer controls.
  always_comb begin
    in_play    = (cur_state == PLAY);
    in_score   = (cur_state == SCORE);
    in_death   = (cur_state == DEATH);
    go_death   = (in_play | in_score) & pacman_dead;
    // Eats only count while frightened; already-pending eats survive regardless.
    pend_next  = pending | (frightened ? ghost_eaten : '0);
    sel_idx    = IDX_W'(lowest_set(MAX_GHOSTS'(pend_next)));
    clr_mask   = '0;
    clr_mask[sel_idx] = 1'b1;
    // A pellet in the same frame as an eat resets the combo before that eat is scored.
    combo_base = (in_play & power_pellet) ? '0 : combo_idx;
    score_val  = SCORE_W'(BASE_GHOST_SCORE) << combo_base;
    do_score   = ~go_death & (pend_next != '0) & (in_play | (in_score & pause_zero));

    fright_load     = go_death | (in_play & power_pellet);
    fright_load_val = go_death ? '0 : FRIGHT_W'(FRIGHT_FRAMES);
    fright_en       = in_play;

    pause_load      = go_death | do_score;
    pause_load_val  = go_death ? PAUSE_W'(DEATH_FRAMES - 1) : PAUSE_W'(SCORE_PAUSE_FRAMES - 1);
    pause_en        = in_score | in_death;
  end

  // Main sequencer FSM with registered outputs; score_add is a one-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state       <= IDLE;
      pending         <= '0;
      combo_idx       <= '0;
      eaten_ghost     <= '0;
      score_add       <= '0;
      anim_cnt        <= '0;
      ghost_animation <= 1'b0;
    end else begin
      score_add <= '0;
      case (cur_state)
        IDLE: begin
          if (start) cur_state <= PLAY;
        end

        PLAY: begin
          if (anim_cnt == ANIM_W'(ANIM_DIV - 1)) begin
            anim_cnt        <= '0;
            ghost_animation <= ~ghost_animation;
          end else begin
            anim_cnt <= anim_cnt + 1'b1;
          end

          if (go_death) begin
            cur_state <= DEATH;
            pending   <= '0;
            combo_idx <= '0;
          end else if (do_score) begin
            cur_state   <= SCORE;
            eaten_ghost <= sel_idx;
            score_add   <= score_val;
            pending     <= pend_next & ~clr_mask;
            combo_idx   <= combo_next(combo_base);
          end else begin
            pending   <= pend_next;
            combo_idx <= combo_base;
          end
        end

        SCORE: begin
          if (go_death) begin
            cur_state <= DEATH;
            pending   <= '0;
            combo_idx <= '0;
          end else if (do_score) begin
            eaten_ghost <= sel_idx;
            score_add   <= score_val;
            pending     <= pend_next & ~clr_mask;
            combo_idx   <= combo_next(combo_base);
          end else begin
            pending <= pend_next;
            if (pause_zero) cur_state <= PLAY;
          end
        end

        DEATH: begin
          if (pause_zero) cur_state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: vector table plus frame-accurate sequences.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        power_pellet;
  logic [3:0]  ghost_eaten;
  logic        pacman_dead;
  logic [1:0]  state;
  logic        pause;
  logic        frightened;
  logic        fright_flash;
  logic [1:0]  eaten_ghost;
  logic [1:0]  combo_idx;
  logic [11:0] score_add;
  logic        ghost_animation;

  always #5 clk = ~clk;

  game_sequencer #(
    .N_GHOSTS           (4),
    .FRIGHT_FRAMES      (360),
    .FLASH_FRAMES       (120),
    .SCORE_PAUSE_FRAMES (60),
    .DEATH_FRAMES       (90),
    .ANIM_DIV           (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .power_pellet    (power_pellet),
    .ghost_eaten     (ghost_eaten),
    .pacman_dead     (pacman_dead),
    .state           (state),
    .pause           (pause),
    .frightened      (frightened),
    .fright_flash    (fright_flash),
    .eaten_ghost     (eaten_ghost),
    .combo_idx       (combo_idx),
    .score_add       (score_add),
    .ghost_animation (ghost_animation)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rst, start, pp, dead;
    logic [3:0] eat;
    logic [1:0] st;
    logic       pause, fr;
    logic [11:0] sadd;
    logic [1:0] eg, combo;
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic        pause, fr;
    logic [11:0] sadd;
    logic [1:0]  eg, combo;
  } exp_t;

  typedef struct {
    logic [1:0]  eg;
    logic [11:0] sadd;
    logic [1:0]  combo;
  } score_exp_t;

  exp_t       sb[$];
  score_exp_t sc_q[$];
  vec_t       tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    start        = 1'b0;
    power_pellet = 1'b0;
    ghost_eaten  = 4'b0000;
    pacman_dead  = 1'b0;
    rst          = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic s, input logic p,
                              input logic d, input logic [3:0] e, input logic [1:0] st,
                              input logic pa, input logic fr, input logic [11:0] sa,
                              input logic [1:0] eg, input logic [1:0] cb);
    vec_t v;
    v.name = n; v.rst = r; v.start = s; v.pp = p; v.dead = d; v.eat = e;
    v.st = st; v.pause = pa; v.fr = fr; v.sadd = sa; v.eg = eg; v.combo = cb;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    exp_t e;
    rst          = v.rst;
    start        = v.start;
    power_pellet = v.pp;
    pacman_dead  = v.dead;
    ghost_eaten  = v.eat;
    e.name = v.name; e.st = v.st; e.pause = v.pause; e.fr = v.fr;
    e.sadd = v.sadd; e.eg = v.eg; e.combo = v.combo;
    sb.push_back(e);
    tick();
    clear_pulses();
    e = sb.pop_front();
    chk({e.name, "_state"}, state, e.st);
    chk({e.name, "_pause"}, pause, e.pause);
    chk({e.name, "_fright"}, frightened, e.fr);
    chk({e.name, "_score_add"}, score_add, e.sadd);
    chk({e.name, "_eaten_ghost"}, eaten_ghost, e.eg);
    chk({e.name, "_combo"}, combo_idx, e.combo);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         t;
    int         last_t;
    int         seen;
    logic       a0;
    logic       frozen;
    score_exp_t se;

    clear_pulses();
    rst = 1'b1;

    //            name               rst st pp dd eat      state pa fr sadd  eg combo
    tbl[0] = mk("reset",            1, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 12'd0, 0, 0);
    tbl[1] = mk("idle_hold",        0, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 12'd0, 0, 0);
    tbl[2] = mk("idle_eat_ignored", 0, 0, 0, 0, 4'b0001, 2'd0, 0, 0, 12'd0, 0, 0);
    tbl[3] = mk("start",            0, 1, 0, 0, 4'b0000, 2'd1, 0, 0, 12'd0, 0, 0);
    tbl[4] = mk("eat_not_fright",   0, 0, 0, 0, 4'b0001, 2'd1, 0, 0, 12'd0, 0, 0);
    tbl[5] = mk("pellet",           0, 0, 1, 0, 4'b0000, 2'd1, 0, 1, 12'd0, 0, 0);
    tbl[6] = mk("eat_g2",           0, 0, 0, 0, 4'b0100, 2'd2, 1, 1, 12'd200, 2, 1);

    for (int i = 0; i < 5; i++) apply_vec(tbl[i]);
    chk("reset_anim", ghost_animation, 0);

    // Animation toggles every ANIM_DIV frames in PLAY
    a0 = ghost_animation; n = 0;
    while (ghost_animation == a0 && n < 20) begin tick(); n++; end
    chk("anim_first_toggle", ghost_animation != a0, 1);
    for (int r = 0; r < 2; r++) begin
      a0 = ghost_animation; n = 0;
      do begin tick(); n++; end while (ghost_animation == a0 && n < 20);
      chk("anim_period", n, 8);
    end
    chk("play_no_pause", pause, 0);

    // Single eat: pause length, anim freeze, fright frozen during pause
    for (int i = 5; i < 7; i++) apply_vec(tbl[i]);
    a0 = ghost_animation; frozen = 1'b1; n = 0;
    while (state == 2'd2 && n < 200) begin
      tick(); n++;
      if (state == 2'd2 && ghost_animation != a0) frozen = 1'b0;
      if (state == 2'd2 && score_add != 0) frozen = 1'b0;
    end
    chk("score_pause_len", n, 60);
    chk("anim_frozen_in_score", frozen, 1);
    chk("back_to_play", state, 1);
    chk("play_pause_low", pause, 0);
    n = 0;
    while (!fright_flash && n < 400) begin tick(); n++; end
    chk("flash_first_frame", n, 239);
    tick();
    chk("flash_blink_off", fright_flash, 0);
    n = 0;
    while (frightened && n < 400) begin tick(); n++; end
    chk("fright_tail_len", n, 119);

    // Full fright duration from a fresh pellet
    power_pellet = 1'b1; tick(); clear_pulses();
    chk("pellet2_fright", frightened, 1);
    chk("pellet2_flash_off", fright_flash, 0);
    n = 0;
    while (frightened && n < 500) begin tick(); n++; end
    chk("fright_len", n, 360);

    // Simultaneous eats serialised ghost 0,1,3 with rising combo
    power_pellet = 1'b1; tick(); clear_pulses();
    chk("pellet3_combo_clr", combo_idx, 0);
    ghost_eaten = 4'b1011;
    se.eg = 2'd0; se.sadd = 12'd200; se.combo = 2'd1; sc_q.push_back(se);
    se.eg = 2'd1; se.sadd = 12'd400; se.combo = 2'd2; sc_q.push_back(se);
    se.eg = 2'd3; se.sadd = 12'd800; se.combo = 2'd3; sc_q.push_back(se);
    tick(); clear_pulses();
    t = 0; last_t = 0; seen = 0;
    while (state != 2'd1 && t < 300) begin
      if (score_add != 0) begin
        if (sc_q.size() == 0) begin
          chk("unexpected_score", score_add, 0);
        end else begin
          se = sc_q.pop_front();
          chk("serial_eaten_ghost", eaten_ghost, se.eg);
          chk("serial_score_add", score_add, se.sadd);
          chk("serial_combo", combo_idx, se.combo);
          if (seen > 0) chk("serial_gap", t - last_t, 60);
          last_t = t;
          seen++;
        end
      end
      tick(); t++;
    end
    chk("serial_scores_seen", seen, 3);
    chk("serial_total_len", t, 180);

    // Fourth and fifth eats saturate at 1600
    ghost_eaten = 4'b0001; tick(); clear_pulses();
    chk("eat4_score", score_add, 1600);
    chk("eat4_ghost", eaten_ghost, 0);
    chk("eat4_combo", combo_idx, 3);
    n = 0;
    while (state != 2'd1 && n < 100) begin tick(); n++; end
    chk("eat4_pause_len", n, 60);
    ghost_eaten = 4'b0010; tick(); clear_pulses();
    chk("eat5_score", score_add, 1600);
    chk("eat5_ghost", eaten_ghost, 1);
    chk("eat5_combo", combo_idx, 3);
    n = 0;
    while (state != 2'd1 && n < 100) begin tick(); n++; end

    // Pellet + eat in one frame scores 200; death mid-SCORE with pending bit
    power_pellet = 1'b1; ghost_eaten = 4'b0011; tick(); clear_pulses();
    chk("pp_eat_state", state, 2);
    chk("pp_eat_score", score_add, 200);
    chk("pp_eat_ghost", eaten_ghost, 0);
    chk("pp_eat_combo", combo_idx, 1);
    chk("pp_eat_fright", frightened, 1);
    repeat (5) tick();
    pacman_dead = 1'b1; tick(); clear_pulses();
    chk("death_state", state, 3);
    chk("death_pause", pause, 1);
    chk("death_fright", frightened, 0);
    chk("death_combo", combo_idx, 0);
    chk("death_score", score_add, 0);
    n = 0;
    while (state == 2'd3 && n < 200) begin tick(); n++; end
    chk("death_len", n, 90);
    chk("death_exit_state", state, 1);
    chk("death_exit_combo", combo_idx, 0);
    chk("death_exit_pause", pause, 0);
    repeat (3) tick();
    chk("pending_cleared_state", state, 1);
    chk("pending_cleared_score", score_add, 0);

    // Reset during SCORE, then eat while not frightened is ignored
    power_pellet = 1'b1; tick(); clear_pulses();
    ghost_eaten = 4'b0100; tick(); clear_pulses();
    chk("pre_rst_state", state, 2);
    repeat (3) tick();
    rst = 1'b1; tick(); clear_pulses();
    chk("rst_state", state, 0);
    chk("rst_pause", pause, 0);
    chk("rst_fright", frightened, 0);
    chk("rst_flash", fright_flash, 0);
    chk("rst_score", score_add, 0);
    chk("rst_ghost", eaten_ghost, 0);
    chk("rst_combo", combo_idx, 0);
    chk("rst_anim", ghost_animation, 0);
    tick();
    chk("rst_idle_hold", state, 0);
    start = 1'b1; tick(); clear_pulses();
    chk("restart_state", state, 1);
    ghost_eaten = 4'b0100; tick(); clear_pulses();
    chk("nofright_eat_score", score_add, 0);
    chk("nofright_eat_state", state, 1);
    tick();
    chk("nofright_eat_later", state, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
